// File: rtl/downsizing.sv
// downsizing: AXI-Stream 2W -> W width converter.
// Each wide word becomes two narrow beats, upper half first. A half word (in_thalf=1)
// produces only its upper beat. tlast is carried onto the final beat of each word.
`timescale 1ns/1ps
module downsizing #(
   parameter int unsigned W = 40
) (
   input  logic           aclk,
   input  logic           aresetn,
   input  logic [2*W-1:0] in_tdata,
   input  logic           in_thalf,
   input  logic           in_tlast,
   input  logic           in_tvalid,
   output logic           in_tready,
   output logic [W-1:0]   out_tdata,
   output logic           out_tlast,
   output logic           out_tvalid,
   input  logic           out_tready
);

   typedef enum logic [1:0] {StEmpty, StHigh, StLow} state_e;

   state_e         state_q;
   logic [W-1:0]   out_tdata_q;
   logic           out_tlast_q;
   logic           out_tvalid_q;
   logic [W-1:0]   hold_data_q;
   logic           hold_last_q;
   logic           in_fire;
   logic           out_fire;

   // Accept a word when nothing is presented, or when the last beat leaves this cycle.
   always_comb begin
      in_tready = aresetn & ((state_q == StEmpty) | ((state_q == StLow) & out_tready));
      in_fire   = in_tvalid & in_tready;
      out_fire  = out_tvalid_q & out_tready;
   end

   // FSM with registered outputs. in_fire is only possible in StEmpty or in StLow with the
   // current beat leaving, so a load takes priority over every other transition.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= StEmpty;
         out_tdata_q  <= '0;
         out_tlast_q  <= 1'b0;
         out_tvalid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_last_q  <= 1'b0;
      end else if (in_fire) begin
         out_tdata_q  <= in_tdata[2*W-1:W];
         out_tvalid_q <= 1'b1;
         if (in_thalf) begin
            out_tlast_q <= in_tlast;
            state_q     <= StLow;
         end else begin
            hold_data_q <= in_tdata[W-1:0];
            hold_last_q <= in_tlast;
            out_tlast_q <= 1'b0;
            state_q     <= StHigh;
         end
      end else begin
         unique case (state_q)
            StEmpty: ;
            StHigh: begin
               if (out_fire) begin
                  out_tdata_q <= hold_data_q;
                  out_tlast_q <= hold_last_q;
                  state_q     <= StLow;
               end
            end
            StLow: begin
               if (out_fire) begin
                  // out_tdata keeps its stale value; it is don't-care once invalid.
                  out_tvalid_q <= 1'b0;
                  out_tlast_q  <= 1'b0;
                  state_q      <= StEmpty;
               end
            end
            default: state_q <= StEmpty;
         endcase
      end
   end

   assign out_tdata  = out_tdata_q;
   assign out_tlast  = out_tlast_q;
   assign out_tvalid = out_tvalid_q;

endmodule

// File: tb/tb_downsizing.sv
// tb_downsizing: scoreboard bench for the 2W -> W downsizer.
`timescale 1ns/1ps
module tb_downsizing;

   localparam int unsigned W = 40;

   logic           aclk = 1'b0;
   logic           aresetn;
   logic [2*W-1:0] in_tdata;
   logic           in_thalf;
   logic           in_tlast;
   logic           in_tvalid;
   logic           in_tready;
   logic [W-1:0]   out_tdata;
   logic           out_tlast;
   logic           out_tvalid;
   logic           out_tready;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [W-1:0] d;
      logic         l;
   } beat_t;

   beat_t exp_q[$];

   downsizing #(.W(W)) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .in_tdata   (in_tdata),
      .in_thalf   (in_thalf),
      .in_tlast   (in_tlast),
      .in_tvalid  (in_tvalid),
      .in_tready  (in_tready),
      .out_tdata  (out_tdata),
      .out_tlast  (out_tlast),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready)
   );

   always #5 aclk = ~aclk;

   function automatic void chk(input string name, input logic [2*W-1:0] act,
                               input logic [2*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Input side of the scoreboard: every accepted word becomes its narrow beats.
   always @(negedge aclk) begin
      if (aresetn === 1'b1 && in_tvalid && in_tready === 1'b1) begin
         if (in_thalf) begin
            exp_q.push_back('{d: in_tdata[2*W-1:W], l: in_tlast});
         end else begin
            exp_q.push_back('{d: in_tdata[2*W-1:W], l: 1'b0});
            exp_q.push_back('{d: in_tdata[W-1:0], l: in_tlast});
         end
      end
   end

   // Output side: pop on every narrow handshake, and check AXI hold rules while stalled.
   logic         stall_q = 1'b0;
   logic [W-1:0] prev_d;
   logic         prev_l;
   beat_t        b;
   always @(negedge aclk) begin
      if (aresetn !== 1'b1) begin
         exp_q.delete();
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            chk("stall_valid", {79'b0, out_tvalid}, 80'd1);
            chk("stall_data", {40'b0, out_tdata}, {40'b0, prev_d});
            chk("stall_last", {79'b0, out_tlast}, {79'b0, prev_l});
         end
         if (out_tvalid === 1'b1 && out_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %h with nothing expected", out_tdata);
            end else begin
               b = exp_q.pop_front();
               chk("beat_data", {40'b0, out_tdata}, {40'b0, b.d});
               chk("beat_last", {79'b0, out_tlast}, {79'b0, b.l});
            end
         end
         stall_q = (out_tvalid === 1'b1) && !out_tready;
         prev_d  = out_tdata;
         prev_l  = out_tlast;
      end
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic [2*W-1:0] d, input logic h, input logic l);
      bit          ok = 1'b0;
      logic [95:0] junk;
      in_tdata  = d;
      in_thalf  = h;
      in_tlast  = l;
      in_tvalid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge aclk);
         if (in_tready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no in_tready expected accept within 1000 cycles");
      end
      step();
      // Junk on idle cycles must never be sampled.
      junk      = {$urandom(), $urandom(), $urandom()};
      in_tvalid = 1'b0;
      in_tdata  = junk[2*W-1:0];
      in_thalf  = junk[90];
      in_tlast  = junk[91];
   endtask

   task automatic drain();
      for (int i = 0; i < 1000; i++) begin
         @(negedge aclk);
         if (exp_q.size() == 0 && out_tvalid === 1'b0) break;
      end
      chk("drain_queue_empty", 80'(exp_q.size()), 80'd0);
      chk("drain_idle", {79'b0, out_tvalid}, 80'd0);
      step();
   endtask

   logic tr[7];
   logic ov[7];

   initial begin
      aresetn    = 1'b0;
      in_tvalid  = 1'b0;
      in_tdata   = '0;
      in_thalf   = 1'b0;
      in_tlast   = 1'b0;
      out_tready = 1'b1;
      repeat (2) @(negedge aclk);
      chk("reset_in_tready", {79'b0, in_tready}, 80'd0);
      chk("reset_out_tvalid", {79'b0, out_tvalid}, 80'd0);
      chk("reset_out_tdata", {40'b0, out_tdata}, 80'd0);
      chk("reset_out_tlast", {79'b0, out_tlast}, 80'd0);
      step();
      aresetn = 1'b1;
      @(negedge aclk);
      chk("idle_in_tready", {79'b0, in_tready}, 80'd1);
      chk("idle_out_tvalid", {79'b0, out_tvalid}, 80'd0);
      step();

      // Back-to-back with out_tready=1.
      fork
         begin
            send("ABCDEFGHIJ", 1'b0, 1'b0);
            send("KLMNOPQRST", 1'b0, 1'b0);
            send("UVWXYZabcd", 1'b0, 1'b1);
         end
         begin
            for (int i = 0; i < 7; i++) begin
               @(negedge aclk);
               tr[i] = in_tready;
               ov[i] = out_tvalid;
            end
         end
      join
      for (int i = 0; i < 6; i++)
         chk($sformatf("b2b_in_tready_%0d", i), {79'b0, tr[i]}, {79'b0, ~i[0]});
      for (int i = 1; i < 7; i++)
         chk($sformatf("b2b_out_tvalid_%0d", i), {79'b0, ov[i]}, 80'd1);
      step();
      drain();

      // Idle cycle between words.
      send("ABCDEFGHIJ", 1'b0, 1'b0);
      step();
      send("KLMNOPQRST", 1'b0, 1'b0);
      step();
      send("UVWXYZabcd", 1'b0, 1'b1);
      drain();

      // Backpressure with KLMNO presented and PQRST held.
      send("ABCDEFGHIJ", 1'b0, 1'b0);
      send("KLMNOPQRST", 1'b0, 1'b0);
      out_tready = 1'b0;
      repeat (8) begin
         @(negedge aclk);
         chk("bp_out_tdata", {40'b0, out_tdata}, {40'b0, "KLMNO"});
         chk("bp_out_tvalid", {79'b0, out_tvalid}, 80'd1);
         chk("bp_in_tready", {79'b0, in_tready}, 80'd0);
      end
      step();
      out_tready = 1'b1;
      send("UVWXYZabcd", 1'b0, 1'b1);
      drain();

      // Half word ends a packet on one beat; full word puts tlast on its second beat.
      send("ABCDE?????", 1'b1, 1'b1);
      send("KLMNOPQRST", 1'b0, 1'b1);
      drain();

      // Random backpressure, random half flags and tlast.
      fork
         begin
            repeat (50) begin
               step();
               out_tready = 1'($urandom_range(0, 1));
            end
            out_tready = 1'b1;
         end
         begin
            for (int i = 0; i < 18; i++) begin
               if ($urandom_range(0, 3) == 0) step();
               send({$urandom(), $urandom(), 16'($urandom())},
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
         end
      join
      out_tready = 1'b1;
      drain();

      // Reset while FGHIJ is held in the HIGH state.
      out_tready = 1'b0;
      send("ABCDEFGHIJ", 1'b0, 1'b0);
      aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      chk("rst_mid_out_tvalid", {79'b0, out_tvalid}, 80'd0);
      chk("rst_mid_out_tdata", {40'b0, out_tdata}, 80'd0);
      chk("rst_mid_in_tready", {79'b0, in_tready}, 80'd0);
      step();
      aresetn    = 1'b1;
      out_tready = 1'b1;
      repeat (5) begin
         @(negedge aclk);
         chk("post_rst_in_tready", {79'b0, in_tready}, 80'd1);
         chk("post_rst_out_tvalid", {79'b0, out_tvalid}, 80'd0);
      end
      chk("final_queue_empty", 80'(exp_q.size()), 80'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish within 500us");
      $fatal(1, "watchdog expired");
   end

endmodule
